accum_xbar_arb: RTL
===================

Name: accum_xbar_arb

Overview:
- Parametrised M-master × Z-zone crossbar for the accumulator memory.
- Generalises the single-router/slot-matrix arrangement into one block:
  - per-zone write and read arbitration, selectable round-robin or fixed priority;
  - grant lock under backpressure;
  - per-zone in-order read tag tracking, so read data returns to the issuing master.
- Sits between compute/DMA masters and the accumulator zone banks.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (M).
- ZONE_WIDTH, 2, zone id width; Z = 2**ZONE_WIDTH zones.
- NUM_BANKS, 4, bank mask width.
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 64, data width.
- TAG_DEPTH, 4, per-zone read tag FIFO depth (power of 2).
- MAX_OUT, 4, per-master outstanding read limit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arb_mode  in  1  0 = round-robin, 1 = fixed priority (master 0 highest).
- m_wr_valid  in  M  write command+data beat valid.
- m_wr_ready  out  M  write accepted.
- m_wr_zone  in  M*ZONE_WIDTH  target zone.
- m_wr_addr  in  M*ADDR_WIDTH  address.
- m_wr_mask  in  M*NUM_BANKS  bank mask.
- m_accum_en  in  M  1 = accumulate, 0 = overwrite.
- m_wdata  in  M*DATA_WIDTH  write data.
- m_rd_valid  in  M  read request valid.
- m_rd_ready  out  M  read accepted.
- m_rd_zone / m_rd_addr / m_rd_mask  in  M*ZONE_WIDTH / M*ADDR_WIDTH / M*NUM_BANKS  read target.
- m_rvalid  out  M  read data valid (no backpressure).
- m_rdata  out  M*DATA_WIDTH  read data.
- z_wr_valid  out  Z  zone write valid.
- z_wr_ready  in  Z  zone write ready.
- z_wr_addr / z_wr_mask / z_accum_en / z_wdata  out  Z-wide slices  granted write fields.
- z_rd_valid  out  Z  zone read valid.
- z_rd_ready  in  Z  zone read ready.
- z_rd_addr / z_rd_mask  out  Z-wide slices  granted read fields.
- z_rvalid  in  Z  zone read data valid (in order per zone, latency ≥1).
- z_rdata  in  Z*DATA_WIDTH  zone read data.
- err_unexp_rsp  out  1  sticky: z_rvalid seen with empty tag FIFO.

Behaviour:
- Reset (rst=1 at posedge):
  - RR pointers = 0; grant locks clear; tag FIFOs empty; outstanding counters = 0; read-zone locks clear; err_unexp_rsp = 0.
  - While rst is high, all m_*_ready, z_*_valid and m_rvalid = 0.
  - A reset mid-transaction discards all tags; responses arriving afterwards set the error flag.
- Write and read arbitration:
  - Independent arbiter per zone and per channel (2·Z arbiters).
  - Requesters for zone z: masters with valid && zone==z.
  - arb_mode=1: lowest index wins.
  - arb_mode=0: first requester at or after rr_ptr wins; rr_ptr ← winner+1 (mod M), updated only on a handshake (z_valid && z_ready).
- Grant lock:
  - If z_*_valid=1 && z_*_ready=0, that arbiter's winner is registered and held next cycle regardless of new requests or mode change, until the handshake.
  - Masters must hold valid and fields stable while not ready.
- Path timing:
  - Grant is combinational, 0-cycle: z_*_valid = winner present (and, for reads, eligible).
  - m_*_ready[i] = granted to i && z_*_ready.
- Read eligibility (master i to zone z), all of:
  - outstanding[i] < MAX_OUT;
  - outstanding[i]==0 or rd_lock_zone[i]==z;
  - tag FIFO z not full.
- Read accept (handshake at zone z, master i):
  - push i into tag FIFO z;
  - outstanding[i]++;
  - rd_lock_zone[i] ← z.
- Read response (z_rvalid[z]):
  - pop FIFO z head h;
  - m_rvalid[h]=1, m_rdata[h]=z_rdata[z], same cycle (combinational);
  - outstanding[h]--.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both occur, count unchanged.
  - Accept and response for the same master in one cycle: counter unchanged.
- Collision freedom: the zone lock guarantees at most one zone returns to a given master per cycle.
- Unexpected response: z_rvalid with empty FIFO → no m_rvalid, err_unexp_rsp ← 1 until reset.
- Width rules: counters are clog2(MAX_OUT+1) bits; FIFO pointers wrap modulo TAG_DEPTH, with an extra bit for full/empty.

Test Plan:
- arb_mode=0, M=2: both masters write zone 1 continuously, z_wr_ready=1 → grants alternate 0,1,0,1; the other zones stay idle.
- z_wr_ready=0 for 3 cycles while master 1 holds the grant, master 0 raises a request → z_wr_addr stays master 1's address; master 1 handshakes in cycle 4; master 0 is granted in cycle 5.
- arb_mode=1: both masters read zone 2 → master 0 always wins; master 1 stalls until master 0 drops valid.
- Master 0 issues 2 reads to zone 0, then a read to zone 3 → the zone-3 read stalls (m_rd_ready=0) until both zone-0 responses return, then is accepted.
- Fill zone 1 tag FIFO with 4 reads (MAX_OUT=4, masters 0,1,0,1) → 5th read held; responses return data to masters 0,1,0,1 in order; a same-cycle pop+push keeps the count at 4.
- Pulse z_rvalid[2] with no outstanding read → no m_rvalid; err_unexp_rsp=1 until rst.

Source files
------------

// File: rtl/accum_xbar_arb_if.sv
// Bus bundle between the compute/DMA masters, the accumulator crossbar and the zone banks.
// The slave modport is the crossbar's view; the master modport is the environment's view.
interface accum_xbar_arb_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ZONE_WIDTH  = 2,
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 64
);
  localparam int NZ = 2**ZONE_WIDTH;

  logic [NUM_MASTERS-1:0]            m_wr_valid, m_wr_ready, m_accum_en;
  logic [NUM_MASTERS*ZONE_WIDTH-1:0] m_wr_zone, m_rd_zone;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wr_addr, m_rd_addr;
  logic [NUM_MASTERS*NUM_BANKS-1:0]  m_wr_mask, m_rd_mask;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata, m_rdata;
  logic [NUM_MASTERS-1:0]            m_rd_valid, m_rd_ready, m_rvalid;

  logic [NZ-1:0]            z_wr_valid, z_wr_ready, z_accum_en;
  logic [NZ-1:0]            z_rd_valid, z_rd_ready, z_rvalid;
  logic [NZ*ADDR_WIDTH-1:0] z_wr_addr, z_rd_addr;
  logic [NZ*NUM_BANKS-1:0]  z_wr_mask, z_rd_mask;
  logic [NZ*DATA_WIDTH-1:0] z_wdata, z_rdata;

  modport slave (
    input  m_wr_valid, m_wr_zone, m_wr_addr, m_wr_mask, m_accum_en, m_wdata,
           m_rd_valid, m_rd_zone, m_rd_addr, m_rd_mask,
           z_wr_ready, z_rd_ready, z_rvalid, z_rdata,
    output m_wr_ready, m_rd_ready, m_rvalid, m_rdata,
           z_wr_valid, z_wr_addr, z_wr_mask, z_accum_en, z_wdata,
           z_rd_valid, z_rd_addr, z_rd_mask
  );

  modport master (
    output m_wr_valid, m_wr_zone, m_wr_addr, m_wr_mask, m_accum_en, m_wdata,
           m_rd_valid, m_rd_zone, m_rd_addr, m_rd_mask,
           z_wr_ready, z_rd_ready, z_rvalid, z_rdata,
    input  m_wr_ready, m_rd_ready, m_rvalid, m_rdata,
           z_wr_valid, z_wr_addr, z_wr_mask, z_accum_en, z_wdata,
           z_rd_valid, z_rd_addr, z_rd_mask
  );
endinterface

// File: rtl/accum_xbar_arb.sv
// M-master x Z-zone crossbar for the accumulator banks: per-zone write/read arbitration with
// grant lock, and per-zone read tag FIFOs that steer responses back to the issuing master.
module accum_xbar_arb #(
  parameter int NUM_MASTERS = 2,
  parameter int ZONE_WIDTH  = 2,
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_DEPTH   = 4,
  parameter int MAX_OUT     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_mode,
  accum_xbar_arb_if.slave bus,
  output logic err_unexp_rsp
);
  localparam int NZ  = 2**ZONE_WIDTH;
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int ZW  = ZONE_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int BW  = NUM_BANKS;
  localparam int DW  = DATA_WIDTH;
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef logic [MIW-1:0] mid_t;

  mid_t                   wr_rr [NZ];
  mid_t                   rd_rr [NZ];
  mid_t                   wr_lock_id [NZ];
  mid_t                   rd_lock_id [NZ];
  mid_t                   wr_win [NZ];
  mid_t                   rd_win [NZ];
  logic [NZ-1:0]          wr_lock, rd_lock, wr_has, rd_has, wr_hs, rd_hs;
  logic [NUM_MASTERS-1:0] wr_req [NZ];
  logic [NUM_MASTERS-1:0] rd_req [NZ];

  mid_t          tag_mem [NZ][TAG_DEPTH];
  logic [PW:0]   tag_wp [NZ];
  logic [PW:0]   tag_rp [NZ];
  logic [NZ-1:0] tag_full, tag_empty, tag_pop;

  logic [CW-1:0] outst [NUM_MASTERS];
  logic [ZW-1:0] rd_zone [NUM_MASTERS];

  // Returns {found, winner}; fixed mode scans from master 0, round-robin from ptr.
  function automatic logic [MIW:0] pick(input logic [NUM_MASTERS-1:0] req, input mid_t ptr,
                                        input logic fixed);
    logic [MIW:0] r;
    int idx;
    r = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = fixed ? k : (int'(ptr) + k) % NUM_MASTERS;
      if (req[idx]) r = {1'b1, MIW'(idx)};
    end
    return r;
  endfunction

  function automatic mid_t nxt(input mid_t w);
    return MIW'((int'(w) + 1) % NUM_MASTERS);
  endfunction

  always_comb begin : arb
    tag_full        = '0;
    tag_empty       = '0;
    wr_has          = '0;
    rd_has          = '0;
    wr_hs           = '0;
    rd_hs           = '0;
    bus.m_wr_ready  = '0;
    bus.m_rd_ready  = '0;
    bus.z_wr_valid  = '0;
    bus.z_rd_valid  = '0;
    bus.z_wr_addr   = '0;
    bus.z_wr_mask   = '0;
    bus.z_accum_en  = '0;
    bus.z_wdata     = '0;
    bus.z_rd_addr   = '0;
    bus.z_rd_mask   = '0;
    for (int z = 0; z < NZ; z++) begin
      wr_req[z] = '0;
      rd_req[z] = '0;
      wr_win[z] = '0;
      rd_win[z] = '0;
      tag_empty[z] = (tag_wp[z] == tag_rp[z]);
      tag_full[z]  = (tag_wp[z] == {~tag_rp[z][PW], tag_rp[z][PW-1:0]});
      for (int i = 0; i < NUM_MASTERS; i++) begin
        wr_req[z][i] = bus.m_wr_valid[i] && (bus.m_wr_zone[i*ZW +: ZW] == ZW'(z));
        rd_req[z][i] = bus.m_rd_valid[i] && (bus.m_rd_zone[i*ZW +: ZW] == ZW'(z))
                       && (outst[i] < CW'(MAX_OUT))
                       && ((outst[i] == '0) || (rd_zone[i] == ZW'(z)))
                       && !tag_full[z];
      end
      // A stalled grant is held until its handshake, whatever else is requesting.
      if (wr_lock[z]) begin
        wr_win[z] = wr_lock_id[z];
        wr_has[z] = bus.m_wr_valid[wr_lock_id[z]];
      end else begin
        {wr_has[z], wr_win[z]} = pick(wr_req[z], wr_rr[z], arb_mode);
      end
      if (rd_lock[z]) begin
        rd_win[z] = rd_lock_id[z];
        rd_has[z] = bus.m_rd_valid[rd_lock_id[z]];
      end else begin
        {rd_has[z], rd_win[z]} = pick(rd_req[z], rd_rr[z], arb_mode);
      end
      bus.z_wr_valid[z] = wr_has[z] && !rst;
      bus.z_rd_valid[z] = rd_has[z] && !rst;
      wr_hs[z] = wr_has[z] && !rst && bus.z_wr_ready[z];
      rd_hs[z] = rd_has[z] && !rst && bus.z_rd_ready[z];
      bus.z_wr_addr[z*AW +: AW] = bus.m_wr_addr[wr_win[z]*AW +: AW];
      bus.z_wr_mask[z*BW +: BW] = bus.m_wr_mask[wr_win[z]*BW +: BW];
      bus.z_accum_en[z]         = bus.m_accum_en[wr_win[z]];
      bus.z_wdata[z*DW +: DW]   = bus.m_wdata[wr_win[z]*DW +: DW];
      bus.z_rd_addr[z*AW +: AW] = bus.m_rd_addr[rd_win[z]*AW +: AW];
      bus.z_rd_mask[z*BW +: BW] = bus.m_rd_mask[rd_win[z]*BW +: BW];
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (wr_hs[z] && (wr_win[z] == MIW'(i))) bus.m_wr_ready[i] = 1'b1;
        if (rd_hs[z] && (rd_win[z] == MIW'(i))) bus.m_rd_ready[i] = 1'b1;
      end
    end
  end

  // The per-master zone lock keeps two zones from returning to one master in a cycle.
  always_comb begin : rsp
    mid_t h;
    h            = '0;
    tag_pop      = '0;
    bus.m_rvalid = '0;
    bus.m_rdata  = '0;
    for (int z = 0; z < NZ; z++) begin
      h = tag_mem[z][tag_rp[z][PW-1:0]];
      if (bus.z_rvalid[z] && !rst && !tag_empty[z] && (int'(h) < NUM_MASTERS)) begin
        tag_pop[z]                  = 1'b1;
        bus.m_rvalid[h]             = 1'b1;
        bus.m_rdata[h*DW +: DW]     = bus.z_rdata[z*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int z = 0; z < NZ; z++) begin
      if (rd_hs[z]) tag_mem[z][tag_wp[z][PW-1:0]] <= rd_win[z];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int z = 0; z < NZ; z++) begin
        wr_rr[z]      <= '0;
        rd_rr[z]      <= '0;
        wr_lock_id[z] <= '0;
        rd_lock_id[z] <= '0;
        tag_wp[z]     <= '0;
        tag_rp[z]     <= '0;
      end
      wr_lock <= '0;
      rd_lock <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        outst[i]   <= '0;
        rd_zone[i] <= '0;
      end
      err_unexp_rsp <= 1'b0;
    end else begin
      for (int z = 0; z < NZ; z++) begin
        wr_lock[z]    <= wr_has[z] && !bus.z_wr_ready[z];
        rd_lock[z]    <= rd_has[z] && !bus.z_rd_ready[z];
        wr_lock_id[z] <= wr_win[z];
        rd_lock_id[z] <= rd_win[z];
        if (wr_hs[z]) wr_rr[z] <= nxt(wr_win[z]);
        if (rd_hs[z]) begin
          rd_rr[z]  <= nxt(rd_win[z]);
          tag_wp[z] <= tag_wp[z] + PTR_ONE;
        end
        if (tag_pop[z]) tag_rp[z] <= tag_rp[z] + PTR_ONE;
        if (bus.z_rvalid[z] && tag_empty[z]) err_unexp_rsp <= 1'b1;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        outst[i] <= outst[i] + CW'(bus.m_rd_ready[i]) - CW'(bus.m_rvalid[i]);
        if (bus.m_rd_ready[i]) rd_zone[i] <= bus.m_rd_zone[i*ZW +: ZW];
      end
    end
  end
endmodule
